atm_ledger_arbiter: RTL and testbench

ATM_LEDGER_ARBITER -- requirements
Module: atm_ledger_arbiter

---
 rtl/atm_ledger_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_atm_ledger_arbiter.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/atm_ledger_arbiter.sv
// Two-port arbitrated ledger: one transaction at a time runs IDLE -> EXEC -> RESP
// against a bank of N_ACCT 32-bit balances; round-robin grant on ties.
module atm_ledger_arbiter #(
    parameter int          N_ACCT   = 4,
    parameter int          ACCT_W   = 2,
    parameter logic [31:0] INIT_BAL = 32'h000186A0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [1:0]        req0_op,
    input  logic [ACCT_W-1:0] req0_acct,
    input  logic [ACCT_W-1:0] req0_dst,
    input  logic [31:0]       req0_amount,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [1:0]        req1_op,
    input  logic [ACCT_W-1:0] req1_acct,
    input  logic [ACCT_W-1:0] req1_dst,
    input  logic [31:0]       req1_amount,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [1:0]        rsp_status,
    output logic [31:0]       rsp_balance,
    output logic [15:0]       txn_count,
    output logic [1:0]        dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both 1;
    // valid never waits on ready, and rsp fields are held until rsp_ready is seen.

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

    localparam logic [1:0] OP_BAL  = 2'b00;
    localparam logic [1:0] OP_DEP  = 2'b01;
    localparam logic [1:0] OP_WDR  = 2'b10;
    localparam logic [1:0] ST_OK   = 2'b00;
    localparam logic [1:0] ST_NSF  = 2'b01;
    localparam logic [1:0] ST_OVF  = 2'b10;
    localparam logic [1:0] ST_BAD  = 2'b11;

    state_t              state_q;
    logic                last_q;
    logic [1:0]          op_q;
    logic [ACCT_W-1:0]   acct_q;
    logic [ACCT_W-1:0]   dst_q;
    logic [31:0]         amt_q;
    logic                id_q;
    logic [31:0]         bal_q [N_ACCT];
    logic                rsp_valid_q;
    logic                rsp_id_q;
    logic [1:0]          rsp_status_q;
    logic [31:0]         rsp_balance_q;
    logic [15:0]         txn_count_q;

    logic                grant0;
    logic                grant1;
    logic [31:0]         src_bal;
    logic [31:0]         dst_bal;
    logic [32:0]         src_sum;
    logic [32:0]         dst_sum;
    logic [1:0]          status_d;
    logic                wr_src_d;
    logic                wr_dst_d;
    logic [31:0]         src_new_d;
    logic [31:0]         dst_new_d;

    // On a tie the port that was not served last wins; last_q resets to 1 so port 0 goes first.
    assign grant0 = req0_valid & (~req1_valid | last_q);
    assign grant1 = req1_valid & (~req0_valid | ~last_q);

    assign req0_ready  = (state_q == IDLE) & grant0;
    assign req1_ready  = (state_q == IDLE) & grant1;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_status  = rsp_status_q;
    assign rsp_balance = rsp_balance_q;
    assign txn_count   = txn_count_q;
    assign dbg_state   = state_q;

    assign src_bal = bal_q[acct_q];
    assign dst_bal = bal_q[dst_q];
    assign src_sum = {1'b0, src_bal} + {1'b0, amt_q};
    assign dst_sum = {1'b0, dst_bal} + {1'b0, amt_q};

    // Transfer checks run in order: same account, then funds, then credit overflow.
    always_comb begin
        status_d  = ST_OK;
        wr_src_d  = 1'b0;
        wr_dst_d  = 1'b0;
        src_new_d = src_bal;
        dst_new_d = dst_bal;
        case (op_q)
            OP_BAL: ;
            OP_DEP: begin
                if (src_sum[32]) begin
                    status_d = ST_OVF;
                end else begin
                    wr_src_d  = 1'b1;
                    src_new_d = src_sum[31:0];
                end
            end
            OP_WDR: begin
                if (amt_q > src_bal) begin
                    status_d = ST_NSF;
                end else begin
                    wr_src_d  = 1'b1;
                    src_new_d = src_bal - amt_q;
                end
            end
            default: begin
                if (dst_q == acct_q) begin
                    status_d = ST_BAD;
                end else if (amt_q > src_bal) begin
                    status_d = ST_NSF;
                end else if (dst_sum[32]) begin
                    status_d = ST_OVF;
                end else begin
                    wr_src_d  = 1'b1;
                    wr_dst_d  = 1'b1;
                    src_new_d = src_bal - amt_q;
                    dst_new_d = dst_sum[31:0];
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            last_q        <= 1'b1;
            op_q          <= 2'b00;
            acct_q        <= '0;
            dst_q         <= '0;
            amt_q         <= 32'd0;
            id_q          <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= 1'b0;
            rsp_status_q  <= ST_OK;
            rsp_balance_q <= 32'd0;
            txn_count_q   <= 16'd0;
            for (int i = 0; i < N_ACCT; i++) begin
                bal_q[i] <= INIT_BAL;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant0 || grant1) begin
                        op_q    <= grant1 ? req1_op     : req0_op;
                        acct_q  <= grant1 ? req1_acct   : req0_acct;
                        dst_q   <= grant1 ? req1_dst    : req0_dst;
                        amt_q   <= grant1 ? req1_amount : req0_amount;
                        id_q    <= grant1;
                        last_q  <= grant1;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    if (wr_src_d) bal_q[acct_q] <= src_new_d;
                    if (wr_dst_d) bal_q[dst_q]  <= dst_new_d;
                    if (status_d == ST_OK) txn_count_q <= txn_count_q + 16'd1;
                    rsp_valid_q   <= 1'b1;
                    rsp_id_q      <= id_q;
                    rsp_status_q  <= status_d;
                    rsp_balance_q <= src_new_d;
                    state_q       <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_atm_ledger_arbiter.sv
// Bench for atm_ledger_arbiter: directed scenarios plus randomized traffic checked
// against a ledger model built from balances, status rules and round-robin order.
module tb_atm_ledger_arbiter;

    localparam logic [31:0] INIT = 32'd100000;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [1:0]  req0_op, req1_op;
    logic [1:0]  req0_acct, req1_acct, req0_dst, req1_dst;
    logic [31:0] req0_amount, req1_amount;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [1:0]  rsp_status;
    logic [31:0] rsp_balance;
    logic [15:0] txn_count;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;

    // driver results
    int          got_n;
    bit          timed_out;
    logic        got_port [2];
    logic        got_id   [2];
    logic [1:0]  got_st   [2];
    logic [31:0] got_bal  [2];
    logic [15:0] got_cnt  [2];
    int          got_lat  [2];

    // reference model
    logic [31:0] model_bal [4];
    logic [15:0] model_cnt;
    int          model_next;

    atm_ledger_arbiter #(.N_ACCT(4), .ACCT_W(2), .INIT_BAL(32'h000186A0)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_acct(req0_acct), .req0_dst(req0_dst), .req0_amount(req0_amount),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_acct(req1_acct), .req1_dst(req1_dst), .req1_amount(req1_amount),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_status(rsp_status), .rsp_balance(rsp_balance),
        .txn_count(txn_count), .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        reset = 1'b1; rsp_ready = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_op = 2'd0; req0_acct = 2'd0; req0_dst = 2'd0; req0_amount = 32'd0;
        req1_op = 2'd0; req1_acct = 2'd0; req1_dst = 2'd0; req1_amount = 32'd0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 4; i++) model_bal[i] = INIT;
        model_cnt  = 16'd0;
        model_next = 0;
    endtask

    // driver: present up to two requests, collect responses in acceptance order
    task automatic drive_pair(input bit v0, input logic [1:0] op0, input logic [1:0] ac0,
                              input logic [1:0] ds0, input logic [31:0] am0,
                              input bit v1, input logic [1:0] op1, input logic [1:0] ac1,
                              input logic [1:0] ds1, input logic [31:0] am1);
        int cyc;
        int total;
        got_n = 0; timed_out = 0;
        total = int'(v0) + int'(v1);
        @(negedge clk);
        req0_valid = v0; req0_op = op0; req0_acct = ac0; req0_dst = ds0; req0_amount = am0;
        req1_valid = v1; req1_op = op1; req1_acct = ac1; req1_dst = ds1; req1_amount = am1;
        for (int k = 0; k < total; k++) begin
            #1;
            cyc = 0;
            while (!(req0_ready || req1_ready) && cyc < 20) begin
                @(negedge clk); #1; cyc++;
            end
            if (cyc >= 20) begin timed_out = 1; break; end
            got_port[k] = req1_ready;
            @(posedge clk); #1;
            if (got_port[k]) req1_valid = 1'b0; else req0_valid = 1'b0;
            @(negedge clk);
            cyc = 1;
            while (!rsp_valid && cyc < 10) begin
                @(negedge clk); cyc++;
            end
            if (!rsp_valid) begin timed_out = 1; break; end
            got_lat[k] = cyc;
            got_id[k]  = rsp_id;
            got_st[k]  = rsp_status;
            got_bal[k] = rsp_balance;
            got_cnt[k] = txn_count;
            got_n++;
            rsp_ready = 1'b1;
            @(posedge clk); #1 rsp_ready = 1'b0;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    function automatic void model_exec(input logic [1:0] op, input logic [1:0] a,
                                       input logic [1:0] d, input logic [31:0] amt,
                                       output logic [1:0] st, output logic [31:0] bal);
        longint s, m, t, lim;
        s = longint'(model_bal[a]); m = longint'(amt); t = longint'(model_bal[d]);
        lim = 64'h0000_0000_FFFF_FFFF;
        st = 2'd0;
        case (op)
            2'd1: if (s + m > lim) st = 2'd2; else model_bal[a] = 32'(s + m);
            2'd2: if (m > s) st = 2'd1; else model_bal[a] = 32'(s - m);
            2'd3: begin
                if (a == d) st = 2'd3;
                else if (m > s) st = 2'd1;
                else if (t + m > lim) st = 2'd2;
                else begin
                    model_bal[a] = 32'(s - m);
                    model_bal[d] = 32'(t + m);
                end
            end
            default: ;
        endcase
        bal = model_bal[a];
    endfunction

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || rsp_id !== 1'b0 || rsp_status !== 2'd0 || rsp_balance !== 32'd0) begin
            errors++;
            $display("FAIL reset_rsp: valid=%b id=%b status=%0d bal=%0d required 0/0/0/0",
                     rsp_valid, rsp_id, rsp_status, rsp_balance);
        end
        checks++;
        if (txn_count !== 16'd0) begin
            errors++; $display("FAIL reset_txn_count: got %0d required 0", txn_count);
        end
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++; $display("FAIL reset_idle_ready: got %b%b required 00", req0_ready, req1_ready);
        end
        req1_valid = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin
            errors++; $display("FAIL single_grant: ready0/1 got %b%b required 01", req0_ready, req1_ready);
        end
        req1_valid = 1'b0;
    endtask

    task automatic test_withdraw();
        do_reset();
        drive_pair(1, 2'd2, 2'd0, 2'd0, 32'd40000, 0, 2'd0, 2'd0, 2'd0, 32'd0);
        checks++;
        if (timed_out || got_n != 1) begin
            errors++; $display("FAIL withdraw_timeout: responses got %0d required 1", got_n);
        end else begin
            checks++;
            if (got_id[0] !== 1'b0 || got_st[0] !== 2'd0 || got_bal[0] !== 32'd60000 || got_cnt[0] !== 16'd1) begin
                errors++;
                $display("FAIL withdraw: id=%b st=%0d bal=%0d cnt=%0d required 0/0/60000/1",
                         got_id[0], got_st[0], got_bal[0], got_cnt[0]);
            end
            checks++;
            if (got_lat[0] != 2) begin
                errors++; $display("FAIL latency: got %0d negedges required 2", got_lat[0]);
            end
        end
    endtask

    task automatic test_tie();
        do_reset();
        drive_pair(1, 2'd2, 2'd1, 2'd0, 32'd60000, 1, 2'd2, 2'd1, 2'd0, 32'd60000);
        checks++;
        if (timed_out || got_n != 2) begin
            errors++; $display("FAIL tie_timeout: responses got %0d required 2", got_n);
        end else begin
            checks++;
            if (got_port[0] !== 1'b0 || got_id[0] !== 1'b0 || got_st[0] !== 2'd0 || got_bal[0] !== 32'd40000) begin
                errors++;
                $display("FAIL tie_first: port=%b id=%b st=%0d bal=%0d required 0/0/0/40000",
                         got_port[0], got_id[0], got_st[0], got_bal[0]);
            end
            checks++;
            if (got_port[1] !== 1'b1 || got_id[1] !== 1'b1 || got_st[1] !== 2'd1 || got_bal[1] !== 32'd40000) begin
                errors++;
                $display("FAIL tie_second: port=%b id=%b st=%0d bal=%0d required 1/1/1/40000",
                         got_port[1], got_id[1], got_st[1], got_bal[1]);
            end
        end
    endtask

    task automatic test_deposit_overflow();
        do_reset();
        drive_pair(0, 2'd0, 2'd0, 2'd0, 32'd0, 1, 2'd1, 2'd2, 2'd0, 32'hFFFFFFFF);
        checks++;
        if (timed_out || got_n != 1 || got_st[0] !== 2'd2 || got_bal[0] !== INIT || got_cnt[0] !== 16'd0) begin
            errors++;
            $display("FAIL deposit_overflow: n=%0d st=%0d bal=%0d cnt=%0d required 1/2/100000/0",
                     got_n, got_st[0], got_bal[0], got_cnt[0]);
        end
    endtask

    task automatic test_transfer();
        do_reset();
        drive_pair(1, 2'd3, 2'd0, 2'd3, 32'd100000, 0, 2'd0, 2'd0, 2'd0, 32'd0);
        checks++;
        if (timed_out || got_n != 1 || got_st[0] !== 2'd0 || got_bal[0] !== 32'd0 || got_cnt[0] !== 16'd1) begin
            errors++;
            $display("FAIL transfer_ok: n=%0d st=%0d bal=%0d cnt=%0d required 1/0/0/1",
                     got_n, got_st[0], got_bal[0], got_cnt[0]);
        end
        drive_pair(1, 2'd0, 2'd3, 2'd0, 32'd0, 0, 2'd0, 2'd0, 2'd0, 32'd0);
        checks++;
        if (timed_out || got_n != 1 || got_st[0] !== 2'd0 || got_bal[0] !== 32'd200000) begin
            errors++;
            $display("FAIL transfer_credit: n=%0d st=%0d bal=%0d required 1/0/200000",
                     got_n, got_st[0], got_bal[0]);
        end
        drive_pair(0, 2'd0, 2'd0, 2'd0, 32'd0, 1, 2'd3, 2'd2, 2'd2, 32'd10);
        checks++;
        if (timed_out || got_n != 1 || got_st[0] !== 2'd3 || got_bal[0] !== INIT || got_cnt[0] !== 16'd2) begin
            errors++;
            $display("FAIL transfer_same_acct: n=%0d st=%0d bal=%0d cnt=%0d required 1/3/100000/2",
                     got_n, got_st[0], got_bal[0], got_cnt[0]);
        end
    endtask

    task automatic test_backpressure();
        int bad;
        do_reset();
        @(negedge clk);
        req0_valid = 1'b1; req0_op = 2'd1; req0_acct = 2'd1; req0_amount = 32'd5;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_op = 2'd0; req1_acct = 2'd1; req1_amount = 32'd0;
        repeat (2) @(negedge clk);
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_status !== 2'd0 || rsp_balance !== 32'd100005 ||
                req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable[%0d]: v=%b id=%b st=%0d bal=%0d rdy=%b%b required 1/0/0/100005/00",
                         c, rsp_valid, rsp_id, rsp_status, rsp_balance, req0_ready, req1_ready);
            end
            if (c < 4) @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || req1_ready !== 1'b1) begin
            errors++;
            $display("FAIL release_idle: rsp_valid=%b ready1=%b required 0/1", rsp_valid, req1_ready);
        end
        @(posedge clk); #1 req1_valid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_balance !== 32'd100005 || rsp_status !== 2'd0) begin
            errors++;
            $display("FAIL after_release: v=%b id=%b st=%0d bal=%0d required 1/1/0/100005",
                     rsp_valid, rsp_id, rsp_status, rsp_balance);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1 rsp_ready = 1'b0;
    endtask

    task automatic test_reset_in_exec();
        int seen;
        do_reset();
        @(negedge clk);
        req0_valid = 1'b1; req0_op = 2'd2; req0_acct = 2'd0; req0_amount = 32'd50;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++; $display("FAIL reset_exec_no_rsp: rsp_valid cycles got %0d required 0", seen);
        end
        drive_pair(1, 2'd0, 2'd0, 2'd0, 32'd0, 0, 2'd0, 2'd0, 2'd0, 32'd0);
        checks++;
        if (timed_out || got_n != 1 || got_bal[0] !== INIT || got_cnt[0] !== 16'd1) begin
            errors++;
            $display("FAIL reset_exec_balance: n=%0d bal=%0d cnt=%0d required 1/100000/1",
                     got_n, got_bal[0], got_cnt[0]);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int t = 0; t < 80; t++) begin
            bit          v [2];
            logic [1:0]  op_r [2];
            logic [1:0]  ac_r [2];
            logic [1:0]  ds_r [2];
            logic [31:0] am_r [2];
            int          order [2];
            int          n, sel, p;
            logic [1:0]  exp_st;
            logic [31:0] exp_bal;
            sel = $urandom_range(0, 2);
            v[0] = (sel != 1);
            v[1] = (sel != 0);
            for (int q = 0; q < 2; q++) begin
                op_r[q] = 2'($urandom_range(0, 3));
                ac_r[q] = 2'($urandom_range(0, 3));
                ds_r[q] = 2'($urandom_range(0, 3));
                case ($urandom_range(0, 4))
                    0:       am_r[q] = 32'd0;
                    1:       am_r[q] = $urandom;
                    2:       am_r[q] = model_bal[ac_r[q]];
                    default: am_r[q] = 32'($urandom_range(0, 150000));
                endcase
            end
            if (v[0] && v[1]) begin
                n = 2; order[0] = model_next; order[1] = 1 - model_next;
            end else begin
                n = 1; order[0] = v[1] ? 1 : 0; order[1] = 0;
            end
            drive_pair(v[0], op_r[0], ac_r[0], ds_r[0], am_r[0], v[1], op_r[1], ac_r[1], ds_r[1], am_r[1]);
            checks++;
            if (timed_out || got_n != n) begin
                errors++; $display("FAIL rand_count[%0d]: responses got %0d required %0d", t, got_n, n);
            end else begin
                for (int k = 0; k < n; k++) begin
                    p = order[k];
                    model_exec(op_r[p], ac_r[p], ds_r[p], am_r[p], exp_st, exp_bal);
                    if (exp_st == 2'd0) model_cnt = model_cnt + 16'd1;
                    model_next = 1 - p;
                    checks++;
                    if (int'(got_id[k]) != p || got_st[k] !== exp_st || got_bal[k] !== exp_bal || got_cnt[k] !== model_cnt) begin
                        errors++;
                        $display("FAIL rand_rsp[%0d.%0d]: id=%b st=%0d bal=%0d cnt=%0d required %0d/%0d/%0d/%0d",
                                 t, k, got_id[k], got_st[k], got_bal[k], got_cnt[k], p, exp_st, exp_bal, model_cnt);
                    end
                end
            end
        end
        for (int a = 0; a < 4; a++) begin
            drive_pair(1, 2'd0, 2'(a), 2'd0, 32'd0, 0, 2'd0, 2'd0, 2'd0, 32'd0);
            model_cnt = model_cnt + 16'd1;
            model_next = 1;
            checks++;
            if (timed_out || got_n != 1 || got_bal[0] !== model_bal[a]) begin
                errors++;
                $display("FAIL rand_final_bal[%0d]: got %0d required %0d", a, got_bal[0], model_bal[a]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_withdraw();
        test_tie();
        test_deposit_overflow();
        test_transfer();
        test_backpressure();
        test_reset_in_exec();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
